// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative MIPS multiply/divide unit:
// operation encodings, FSM states and small decode helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } state_e;

  // Iteration counter must be able to hold WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return ~op[0];
  endfunction

  function automatic logic is_div_op(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Combinational conditional two's-complement negation: y = neg ? -x : x.
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the MIPS HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e                 state, state_next;
  op_e                    op_q;
  logic                   sa, sb, b_zero;
  logic [WIDTH-1:0]       mag_b;
  logic [2*WIDTH-1:0]     acc;
  logic [CNT_W-1:0]       cnt;

  op_e                    op_in;
  logic                   sa_in, sb_in, accept;
  logic [WIDTH-1:0]       mag_a_in, mag_b_in;

  logic [WIDTH:0]         mul_sum, div_cand, div_diff;
  logic [2*WIDTH-1:0]     acc_step;
  logic [2*WIDTH-1:0]     prod_fixed;
  logic [WIDTH-1:0]       quo_fixed, rem_fixed;

  assign op_in  = op_e'(op);
  assign sa_in  = is_signed_op(op_in) & a[WIDTH-1];
  assign sb_in  = is_signed_op(op_in) & b[WIDTH-1];
  assign accept = (state == ST_IDLE) && start;
  assign busy   = (state != ST_IDLE);

  cond_negate #(.WIDTH(WIDTH)) u_neg_a (.neg(sa_in), .x(a), .y(mag_a_in));
  cond_negate #(.WIDTH(WIDTH)) u_neg_b (.neg(sb_in), .x(b), .y(mag_b_in));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: defaults assigned first so no path through the always_comb infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_CALC;
      ST_CALC: if (cnt == CNT_W'(WIDTH - 1)) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  // A zero divisor always passes the compare, yielding an all-ones quotient and rem = |a|.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    div_cand = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_cand - {1'b0, mag_b};
    acc_step = {mul_sum, acc[WIDTH-1:1]};
    if (is_div_op(op_q)) begin
      if (div_cand >= {1'b0, mag_b}) acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                           acc_step = {div_cand[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // NOTE: pure datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op_in;
      sa     <= sa_in;
      sb     <= sb_in;
      b_zero <= (b == '0);
      mag_b  <= mag_b_in;
      acc    <= {{WIDTH{1'b0}}, mag_a_in};
      cnt    <= '0;
    end else if (state == ST_CALC) begin
      acc <= acc_step;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Negating |rem| by sa restores the original dividend for divide-by-zero.
  cond_negate #(.WIDTH(2*WIDTH)) u_neg_prod (.neg(sa ^ sb), .x(acc), .y(prod_fixed));
  cond_negate #(.WIDTH(WIDTH)) u_neg_quo (
    .neg((sa ^ sb) & ~b_zero), .x(acc[WIDTH-1:0]), .y(quo_fixed)
  );
  cond_negate #(.WIDTH(WIDTH)) u_neg_rem (.neg(sa), .x(acc[2*WIDTH-1:WIDTH]), .y(rem_fixed));

  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == ST_FIX);
      if (state == ST_FIX) begin
        if (is_div_op(op_q)) begin
          hi <= rem_fixed;
          lo <= quo_fixed;
        end else begin
          hi <= prod_fixed[2*WIDTH-1:WIDTH];
          lo <= prod_fixed[WIDTH-1:0];
        end
      end else if (state == ST_IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule
